mcu_ctrl: RTL and testbench
===========================

MCU_CTRL -- requirements
Module: mcu_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port instr  input  32  instruction memory read data; sampled only in FETCH.
REQ-004 SHALL have port mem_ready  input  1  memory access complete (instruction fetch or data access).
REQ-005 SHALL have port zero  input  1  ALU zero flag.
REQ-006 SHALL have port ALUop  output  5  ALU operation code; encoding per REQ-016.
REQ-007 SHALL have ports PCWr, IRWr, RegWr, MemRd, MemWr, ExtOp, ALUSrcB  output  1 each  PC write, IR write, register write, data read, data write, sign-extend, immediate-operand select.
REQ-008 SHALL have ports RegDst[1:0] (0 rt, 1 rd, 2 $31), MemtoReg[1:0] (0 ALU, 1 mem, 2 PC+4), PCSrc[1:0] (0 PC+4, 1 branch, 2 jump, 3 register)  output.
REQ-009 SHALL have ports state[2:0]  output  current FSM state, and illegal  output  1  sticky illegal-instruction flag.

Function
REQ-010 SHALL implement states FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH on next edge.
REQ-011 In FETCH: MemRd=1; hold FETCH while mem_ready=0; when mem_ready=1, assert IRWr=1 and PCWr=1 (PCSrc=0), latch op=instr[31:26], funct=instr[5:0], shamt-use flag, then go to DECODE.
REQ-012 DECODE SHALL last exactly one cycle and go to EXE for every supported instruction; unsupported op/funct SHALL set illegal=1 and return to FETCH with no write strobes.
REQ-013 EXE: R-type ALU ops and addiu/ori/lui -> WB; lw/sw -> MEM; beq, j, jal, jr, jalr -> FETCH.
REQ-014 MEM: MemRd=1 (lw) or MemWr=1 (sw) held while mem_ready=0; on mem_ready=1 lw -> WB, sw -> FETCH; MemWr SHALL be high for the stall cycles plus the completing cycle.
REQ-015 WB: RegWr=1 for exactly one cycle, then FETCH; RegDst=1 for R-type, 0 for immediate/lw; MemtoReg=1 for lw, else 0.
REQ-016 ALUop SHALL be driven in EXE (held through MEM/WB): add/addu/addiu/lw/sw 00000; sub/subu/beq 00001; slt 00010; and 00011; nor 00100; or/ori 00101; xor 00110; sll 00111; srl 01000; sltu 01001; jal/jalr 01010; jr 01011; sllv 01100; sra 01101; srav 01110; srlv 01111; lui 10000; all other cycles 00000.
REQ-017 ALUSrcB=1 for addiu, ori, lui, lw, sw; ExtOp=1 for addiu, lw, sw, beq; ExtOp=0 for ori, lui.
REQ-018 beq in EXE: PCWr=zero, PCSrc=1.
REQ-019 j in EXE: PCWr=1, PCSrc=2; jal additionally RegWr=1, RegDst=2, MemtoReg=2.
REQ-020 jr in EXE: PCWr=1, PCSrc=3; jalr additionally RegWr=1, RegDst=1, MemtoReg=2.
REQ-021 All write strobes (PCWr, IRWr, RegWr, MemWr) SHALL be 0 in any state/instruction combination not listed above.
REQ-022 Cycle counts with mem_ready tied high: R-type/immediate 4, lw 5, sw 4, beq/j/jal/jr/jalr 3.
REQ-023 illegal SHALL remain 1 until reset and SHALL NOT block further execution.

Reset
REQ-024 While rst=1 at a clock edge: state=FETCH, latched op/funct=0, illegal=0, all write strobes 0, ALUop=00000.
REQ-025 rst asserted mid-instruction (including during a MEM stall) SHALL abort it with no write strobe in the following cycle; execution resumes in FETCH after rst falls.

Verification
REQ-026 addu (op 0, funct 100001), mem_ready=1 -> states 0,1,2,4; ALUop=00000 in EXE; RegWr=1, RegDst=1 only in WB.
REQ-027 lw (op 100011), mem_ready low 3 cycles in MEM -> MEM held 4 cycles, then WB with MemtoReg=1, RegDst=0; total 8 cycles.
REQ-028 beq (op 000100) with zero=1, then zero=0 -> PCWr=1/PCSrc=1 in first EXE, PCWr=0 in second; both return to FETCH after 3 cycles.
REQ-029 jal (op 000011) -> EXE: PCWr=1, PCSrc=2, RegWr=1, RegDst=2, MemtoReg=2, ALUop=01010.
REQ-030 op 111111 -> illegal=1 after DECODE, no strobes, next instruction executes normally with illegal still 1.
REQ-031 rst pulsed during sw MEM stall -> MemWr=0 next cycle, state=0, illegal=0.

Source files
------------

// File: rtl/mcu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mcu_ctrl_if
// Description : Instruction/memory handshake and datapath control bundle
//               between the multicycle controller and its datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface mcu_ctrl_if;
    logic [31:0] instr;
    logic        mem_ready;
    logic        zero;
    logic [4:0]  ALUop;
    logic        PCWr;
    logic        IRWr;
    logic        RegWr;
    logic        MemRd;
    logic        MemWr;
    logic        ExtOp;
    logic        ALUSrcB;
    logic [1:0]  RegDst;
    logic [1:0]  MemtoReg;
    logic [1:0]  PCSrc;
    logic [2:0]  state;
    logic        illegal;

    // Controller side
    modport master (
        input  instr, mem_ready, zero,
        output ALUop, PCWr, IRWr, RegWr, MemRd, MemWr, ExtOp, ALUSrcB,
               RegDst, MemtoReg, PCSrc, state, illegal
    );

    // Datapath side
    modport slave (
        output instr, mem_ready, zero,
        input  ALUop, PCWr, IRWr, RegWr, MemRd, MemWr, ExtOp, ALUSrcB,
               RegDst, MemtoReg, PCSrc, state, illegal
    );
endinterface
`default_nettype wire

// File: rtl/mcu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mcu_ctrl
// Description : Five-state multicycle MIPS-subset controller (FETCH, DECODE,
//               EXE, MEM, WB) with sticky illegal-instruction detection.
// Revision    : 1.0 - initial release
// ============================================================================
module mcu_ctrl (
    input  wire logic  clk,
    input  wire logic  rst,
    mcu_ctrl_if.master bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_JALR = 6'b001001;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXE    = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t     cur_state;
    logic [5:0] op;
    logic [5:0] funct;
    logic       shamt_use;
    logic       illegal_q;
    logic [4:0] alu_op_q;

    logic       k_alu_r, k_imm, k_lw, k_sw, k_beq, k_j, k_jal, k_jr, k_jalr;
    logic       supported;
    logic [4:0] dec_alu;
    logic       dec_srcb, dec_ext;
    logic       unused_bits;

    // Rest of the instruction word is consumed by the datapath, not here
    assign unused_bits = ^{bus.instr[25:6], shamt_use};

    always_comb begin
        k_alu_r   = 1'b0;
        k_imm     = 1'b0;
        k_lw      = 1'b0;
        k_sw      = 1'b0;
        k_beq     = 1'b0;
        k_j       = 1'b0;
        k_jal     = 1'b0;
        k_jr      = 1'b0;
        k_jalr    = 1'b0;
        supported = 1'b1;
        dec_alu   = 5'd0;
        case (op)
            OP_RTYPE: begin
                k_alu_r = 1'b1;
                case (funct)
                    F_ADD, F_ADDU: dec_alu = 5'd0;
                    F_SUB, F_SUBU: dec_alu = 5'd1;
                    F_SLT:         dec_alu = 5'd2;
                    F_AND:         dec_alu = 5'd3;
                    F_NOR:         dec_alu = 5'd4;
                    F_OR:          dec_alu = 5'd5;
                    F_XOR:         dec_alu = 5'd6;
                    F_SLL:         dec_alu = 5'd7;
                    F_SRL:         dec_alu = 5'd8;
                    F_SLTU:        dec_alu = 5'd9;
                    F_SLLV:        dec_alu = 5'd12;
                    F_SRA:         dec_alu = 5'd13;
                    F_SRAV:        dec_alu = 5'd14;
                    F_SRLV:        dec_alu = 5'd15;
                    F_JR:   begin k_alu_r = 1'b0; k_jr   = 1'b1; dec_alu = 5'd11; end
                    F_JALR: begin k_alu_r = 1'b0; k_jalr = 1'b1; dec_alu = 5'd10; end
                    default: begin k_alu_r = 1'b0; supported = 1'b0; end
                endcase
            end
            OP_ADDIU: begin k_imm = 1'b1; dec_alu = 5'd0;  end
            OP_ORI:   begin k_imm = 1'b1; dec_alu = 5'd5;  end
            OP_LUI:   begin k_imm = 1'b1; dec_alu = 5'd16; end
            OP_LW:    begin k_lw  = 1'b1; dec_alu = 5'd0;  end
            OP_SW:    begin k_sw  = 1'b1; dec_alu = 5'd0;  end
            OP_BEQ:   begin k_beq = 1'b1; dec_alu = 5'd1;  end
            OP_J:     begin k_j   = 1'b1; dec_alu = 5'd0;  end
            OP_JAL:   begin k_jal = 1'b1; dec_alu = 5'd10; end
            default:  supported = 1'b0;
        endcase
        dec_srcb = k_imm | k_lw | k_sw;
        dec_ext  = (op == OP_ADDIU) | k_lw | k_sw | k_beq;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= FETCH;
            op        <= 6'd0;
            funct     <= 6'd0;
            shamt_use <= 1'b0;
            illegal_q <= 1'b0;
            alu_op_q  <= 5'd0;
        end else begin
            case (cur_state)
                FETCH: begin
                    alu_op_q <= 5'd0;
                    if (bus.mem_ready) begin
                        op        <= bus.instr[31:26];
                        funct     <= bus.instr[5:0];
                        shamt_use <= (bus.instr[31:26] == OP_RTYPE) &&
                                     ((bus.instr[5:0] == F_SLL) ||
                                      (bus.instr[5:0] == F_SRL) ||
                                      (bus.instr[5:0] == F_SRA));
                        cur_state <= DECODE;
                    end
                end
                DECODE: begin
                    if (supported) begin
                        alu_op_q  <= dec_alu;
                        cur_state <= EXE;
                    end else begin
                        illegal_q <= 1'b1;
                        cur_state <= FETCH;
                    end
                end
                EXE: begin
                    if (k_lw || k_sw) begin
                        cur_state <= MEM;
                    end else if (k_alu_r || k_imm) begin
                        cur_state <= WB;
                    end else begin
                        alu_op_q  <= 5'd0;
                        cur_state <= FETCH;
                    end
                end
                MEM: begin
                    if (bus.mem_ready) begin
                        if (k_lw) begin
                            cur_state <= WB;
                        end else begin
                            alu_op_q  <= 5'd0;
                            cur_state <= FETCH;
                        end
                    end
                end
                WB: begin
                    alu_op_q  <= 5'd0;
                    cur_state <= FETCH;
                end
                default: begin
                    alu_op_q  <= 5'd0;
                    cur_state <= FETCH;
                end
            endcase
        end
    end

    always_comb begin
        bus.PCWr     = 1'b0;
        bus.IRWr     = 1'b0;
        bus.RegWr    = 1'b0;
        bus.MemRd    = 1'b0;
        bus.MemWr    = 1'b0;
        bus.ExtOp    = 1'b0;
        bus.ALUSrcB  = 1'b0;
        bus.RegDst   = 2'd0;
        bus.MemtoReg = 2'd0;
        bus.PCSrc    = 2'd0;
        case (cur_state)
            FETCH: begin
                bus.MemRd = 1'b1;
                bus.IRWr  = bus.mem_ready;
                bus.PCWr  = bus.mem_ready;
            end
            EXE: begin
                bus.ALUSrcB = dec_srcb;
                bus.ExtOp   = dec_ext;
                if (k_beq) begin
                    bus.PCWr  = bus.zero;
                    bus.PCSrc = 2'd1;
                end
                if (k_j || k_jal) begin
                    bus.PCWr  = 1'b1;
                    bus.PCSrc = 2'd2;
                end
                if (k_jr || k_jalr) begin
                    bus.PCWr  = 1'b1;
                    bus.PCSrc = 2'd3;
                end
                if (k_jal || k_jalr) begin
                    bus.RegWr    = 1'b1;
                    bus.RegDst   = k_jal ? 2'd2 : 2'd1;
                    bus.MemtoReg = 2'd2;
                end
            end
            MEM: begin
                bus.ALUSrcB = dec_srcb;
                bus.ExtOp   = dec_ext;
                bus.MemRd   = k_lw;
                bus.MemWr   = k_sw;
            end
            WB: begin
                bus.ALUSrcB  = dec_srcb;
                bus.ExtOp    = dec_ext;
                bus.RegWr    = 1'b1;
                bus.RegDst   = k_alu_r ? 2'd1 : 2'd0;
                bus.MemtoReg = k_lw ? 2'd1 : 2'd0;
            end
            default: ;
        endcase
        // Reset kills every write strobe in the cycle it is asserted
        if (rst) begin
            bus.PCWr  = 1'b0;
            bus.IRWr  = 1'b0;
            bus.RegWr = 1'b0;
            bus.MemWr = 1'b0;
        end
    end

    assign bus.ALUop   = alu_op_q;
    assign bus.state   = cur_state;
    assign bus.illegal = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_mcu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcu_ctrl
// Description : Scoreboard bench for mcu_ctrl: expected per-cycle controls are
//               queued as each cycle is driven and compared on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcu_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       pcwr, irwr, regwr, memrd, memwr, alusrcb, extop;
        logic [4:0] aluop;
        logic [1:0] regdst, memtoreg, pcsrc;
        logic       ill;
    } exp_t;

    typedef enum int {K_R, K_IMM, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR, K_JALR, K_ILL} kind_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic ill_m;
    exp_t sb[$];

    mcu_ctrl_if bus ();

    mcu_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("state",    32'(bus.state),    32'(e.st));
            check_eq("PCWr",     32'(bus.PCWr),     32'(e.pcwr));
            check_eq("IRWr",     32'(bus.IRWr),     32'(e.irwr));
            check_eq("RegWr",    32'(bus.RegWr),    32'(e.regwr));
            check_eq("MemRd",    32'(bus.MemRd),    32'(e.memrd));
            check_eq("MemWr",    32'(bus.MemWr),    32'(e.memwr));
            check_eq("ALUSrcB",  32'(bus.ALUSrcB),  32'(e.alusrcb));
            check_eq("ExtOp",    32'(bus.ExtOp),    32'(e.extop));
            check_eq("ALUop",    32'(bus.ALUop),    32'(e.aluop));
            check_eq("RegDst",   32'(bus.RegDst),   32'(e.regdst));
            check_eq("MemtoReg", 32'(bus.MemtoReg), 32'(e.memtoreg));
            check_eq("PCSrc",    32'(bus.PCSrc),    32'(e.pcsrc));
            check_eq("illegal",  32'(bus.illegal),  32'(e.ill));
        end
    end

    // Reference decode table: class, ALU code, operand-B select, sign-extend
    function automatic void info(input logic [31:0] ins, output kind_t k,
                                 output logic [4:0] a, output logic sb_o, output logic ex);
        logic [5:0] o;
        logic [5:0] f;
        o = ins[31:26];
        f = ins[5:0];
        k = K_ILL; a = 5'd0; sb_o = 1'b0; ex = 1'b0;
        case (o)
            6'h00: case (f)
                6'h20, 6'h21: begin k = K_R; a = 5'd0;  end
                6'h22, 6'h23: begin k = K_R; a = 5'd1;  end
                6'h2A:        begin k = K_R; a = 5'd2;  end
                6'h24:        begin k = K_R; a = 5'd3;  end
                6'h27:        begin k = K_R; a = 5'd4;  end
                6'h25:        begin k = K_R; a = 5'd5;  end
                6'h26:        begin k = K_R; a = 5'd6;  end
                6'h00:        begin k = K_R; a = 5'd7;  end
                6'h02:        begin k = K_R; a = 5'd8;  end
                6'h2B:        begin k = K_R; a = 5'd9;  end
                6'h04:        begin k = K_R; a = 5'd12; end
                6'h03:        begin k = K_R; a = 5'd13; end
                6'h07:        begin k = K_R; a = 5'd14; end
                6'h06:        begin k = K_R; a = 5'd15; end
                6'h08:        begin k = K_JR;   a = 5'd11; end
                6'h09:        begin k = K_JALR; a = 5'd10; end
                default:      k = K_ILL;
            endcase
            6'h09: begin k = K_IMM; a = 5'd0;  sb_o = 1'b1; ex = 1'b1; end
            6'h0D: begin k = K_IMM; a = 5'd5;  sb_o = 1'b1; end
            6'h0F: begin k = K_IMM; a = 5'd16; sb_o = 1'b1; end
            6'h23: begin k = K_LW;  a = 5'd0;  sb_o = 1'b1; ex = 1'b1; end
            6'h2B: begin k = K_SW;  a = 5'd0;  sb_o = 1'b1; ex = 1'b1; end
            6'h04: begin k = K_BEQ; a = 5'd1;  ex = 1'b1; end
            6'h02: begin k = K_J;   a = 5'd0;  end
            6'h03: begin k = K_JAL; a = 5'd10; end
            default: k = K_ILL;
        endcase
    endfunction

    task automatic drive(input logic [31:0] ins, input logic mr, input logic z,
                         input logic r, input exp_t e, input bit do_chk);
        bus.instr     = ins;
        bus.mem_ready = mr;
        bus.zero      = z;
        rst           = r;
        if (do_chk) sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t fetch_exp(input logic mr);
        exp_t e;
        e       = '0;
        e.st    = 3'd0;
        e.memrd = 1'b1;
        e.pcwr  = mr;
        e.irwr  = mr;
        e.ill   = ill_m;
        return e;
    endfunction

    task automatic run(input logic [31:0] ins, input int fstall, input int mstall, input logic z);
        kind_t      k;
        logic [4:0] a;
        logic       srcb, ext;
        exp_t       e;
        info(ins, k, a, srcb, ext);
        for (int i = 0; i < fstall; i++) drive(ins, 1'b0, z, 1'b0, fetch_exp(1'b0), 1'b1);
        drive(ins, 1'b1, z, 1'b0, fetch_exp(1'b1), 1'b1);
        e = '0; e.st = 3'd1; e.ill = ill_m;
        drive($urandom, 1'b1, z, 1'b0, e, 1'b1);
        if (k == K_ILL) begin
            ill_m = 1'b1;
            return;
        end
        e = '0; e.st = 3'd2; e.aluop = a; e.alusrcb = srcb; e.extop = ext; e.ill = ill_m;
        case (k)
            K_BEQ:  begin e.pcwr = z;    e.pcsrc = 2'd1; end
            K_J:    begin e.pcwr = 1'b1; e.pcsrc = 2'd2; end
            K_JAL:  begin e.pcwr = 1'b1; e.pcsrc = 2'd2; e.regwr = 1'b1; e.regdst = 2'd2; e.memtoreg = 2'd2; end
            K_JR:   begin e.pcwr = 1'b1; e.pcsrc = 2'd3; end
            K_JALR: begin e.pcwr = 1'b1; e.pcsrc = 2'd3; e.regwr = 1'b1; e.regdst = 2'd1; e.memtoreg = 2'd2; end
            default: ;
        endcase
        drive($urandom, 1'b1, z, 1'b0, e, 1'b1);
        if (k == K_LW || k == K_SW) begin
            e = '0; e.st = 3'd3; e.aluop = a; e.alusrcb = srcb; e.extop = ext; e.ill = ill_m;
            e.memrd = (k == K_LW);
            e.memwr = (k == K_SW);
            for (int i = 0; i < mstall; i++) drive($urandom, 1'b0, z, 1'b0, e, 1'b1);
            drive($urandom, 1'b1, z, 1'b0, e, 1'b1);
        end
        if (k == K_R || k == K_IMM || k == K_LW) begin
            e = '0; e.st = 3'd4; e.aluop = a; e.alusrcb = srcb; e.extop = ext; e.ill = ill_m;
            e.regwr    = 1'b1;
            e.regdst   = (k == K_R) ? 2'd1 : 2'd0;
            e.memtoreg = (k == K_LW) ? 2'd1 : 2'd0;
            drive($urandom, 1'b1, z, 1'b0, e, 1'b1);
        end
    endtask

    task automatic sw_reset_abort();
        exp_t e;
        drive(32'hAC000000, 1'b1, 1'b0, 1'b0, fetch_exp(1'b1), 1'b1);
        e = '0; e.st = 3'd1; e.ill = ill_m;
        drive($urandom, 1'b1, 1'b0, 1'b0, e, 1'b1);
        e = '0; e.st = 3'd2; e.alusrcb = 1'b1; e.extop = 1'b1; e.ill = ill_m;
        drive($urandom, 1'b1, 1'b0, 1'b0, e, 1'b1);
        e.st = 3'd3; e.memwr = 1'b1;
        drive($urandom, 1'b0, 1'b0, 1'b0, e, 1'b1);
        e = '0;
        drive($urandom, 1'b0, 1'b0, 1'b1, e, 1'b0);
        ill_m = 1'b0;
        drive($urandom, 1'b0, 1'b0, 1'b0, fetch_exp(1'b0), 1'b1);
    endtask

    initial begin
        exp_t e;
        errors = 0;
        checks = 0;
        ill_m  = 1'b0;
        e      = '0;
        drive(32'h0, 1'b1, 1'b0, 1'b1, e, 1'b0);
        e.memrd = 1'b1;
        drive(32'h0, 1'b1, 1'b0, 1'b1, e, 1'b1);

        run(32'h00000021, 0, 0, 1'b0);
        run(32'h8C000000, 0, 3, 1'b0);
        run(32'h10000000, 0, 0, 1'b1);
        run(32'h10000000, 1, 0, 1'b0);
        run(32'h0C000000, 0, 0, 1'b0);
        run(32'h00000022, 0, 0, 1'b0);
        run(32'h0000002A, 0, 0, 1'b0);
        run(32'h00000027, 0, 0, 1'b0);
        run(32'h00000040, 0, 0, 1'b0);
        run(32'h00000003, 0, 0, 1'b0);
        run(32'h00000007, 0, 0, 1'b0);
        run(32'h00000006, 0, 0, 1'b0);
        run(32'h0000002B, 0, 0, 1'b0);
        run(32'h00000004, 0, 0, 1'b0);
        run(32'h24000000, 0, 0, 1'b0);
        run(32'h3C000000, 0, 0, 1'b0);
        run(32'h08000000, 0, 0, 1'b0);
        run(32'h00000008, 0, 0, 1'b0);
        run(32'h00000009, 0, 0, 1'b0);
        run(32'hAC000000, 2, 0, 1'b0);
        run(32'hFC000000, 0, 0, 1'b0);
        run(32'h34000000, 0, 0, 1'b0);
        run(32'h00000001, 0, 0, 1'b0);
        run(32'hAC000000, 0, 2, 1'b0);
        sw_reset_abort();
        run(32'h00000021, 0, 0, 1'b0);
        drive(32'h0, 1'b0, 1'b0, 1'b0, fetch_exp(1'b0), 1'b1);

        check_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
